// File: rtl/cplx_frame_pkg.sv
// Shared definitions for the complex IQ frame sequencer.
// This package holds the state encoding and the default widths.
package cplx_frame_pkg;

    localparam int DATA_SIZE_DEF = 16;
    localparam int LEN_SIZE_DEF  = 16;
    localparam int CNT_SIZE_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/frame_len_cnt.sv
// Per-frame sample counter for the IQ frame sequencer.
// It raises first/last flags for the sample currently being presented.
module frame_len_cnt
    import cplx_frame_pkg::*;
#(
    parameter int LEN_SIZE = LEN_SIZE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                adv,
    input  logic [LEN_SIZE-1:0] len,
    output logic                first,
    output logic                last
);

    logic [LEN_SIZE-1:0] cnt_q;
    logic [LEN_SIZE-1:0] cnt_d;

    assign first = (cnt_q == {LEN_SIZE{1'b0}});
    assign last  = (cnt_q == (len - LEN_SIZE'(1)));

    // next count: clear on arm, wrap to zero after the last sample of a frame
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {LEN_SIZE{1'b0}};
        end else if (adv) begin
            if (last) begin
                cnt_d = {LEN_SIZE{1'b0}};
            end else begin
                cnt_d = cnt_q + LEN_SIZE'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {LEN_SIZE{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cplx_frame_seq.sv
// Frame sequencer for the complex IQ stream: it gates samples into
// fixed-length frames and marks each frame with sof and eof.
module cplx_frame_seq
    import cplx_frame_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int LEN_SIZE  = LEN_SIZE_DEF,
    parameter int CNT_SIZE  = CNT_SIZE_DEF
) (
    input  logic                 data_clk_i,
    input  logic                 data_rst_i,
    input  logic [DATA_SIZE-1:0] data_i_i,
    input  logic [DATA_SIZE-1:0] data_q_i,
    input  logic                 data_en_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [LEN_SIZE-1:0]  frame_len_i,
    input  logic [CNT_SIZE-1:0]  nb_frames_i,
    output logic [DATA_SIZE-1:0] data_i_o,
    output logic [DATA_SIZE-1:0] data_q_o,
    output logic                 data_en_o,
    output logic                 data_sof_o,
    output logic                 data_eof_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_SIZE-1:0]  frame_cnt_o
);

    state_t                state_q, state_d;
    logic [LEN_SIZE-1:0]   len_q, len_d;
    logic [CNT_SIZE-1:0]   nb_q, nb_d;
    logic [CNT_SIZE-1:0]   frame_cnt_q, frame_cnt_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [DATA_SIZE-1:0]  di_q, di_d;
    logic [DATA_SIZE-1:0]  dq_q, dq_d;
    logic                  en_q, en_d;
    logic                  sof_q, sof_d;
    logic                  eof_q, eof_d;

    logic fwd;
    logic start_ok;
    logic first;
    logic last;
    logic last_frame;

    assign fwd        = data_en_i && (state_q != ST_IDLE);
    assign start_ok   = (state_q == ST_IDLE) && start_i && !stop_i
                        && (frame_len_i != {LEN_SIZE{1'b0}});
    assign last_frame = (nb_q != {CNT_SIZE{1'b0}})
                        && ((frame_cnt_q + CNT_SIZE'(1)) == nb_q);

    frame_len_cnt #(.LEN_SIZE(LEN_SIZE)) u_len_cnt (
        .clk   (data_clk_i),
        .rst   (data_rst_i),
        .clr   (start_ok),
        .adv   (fwd),
        .len   (len_q),
        .first (first),
        .last  (last)
    );

    // sequencer next-state, config latch, frame count and output stage
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        nb_d        = nb_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;

        if (fwd && last) begin
            frame_cnt_d = frame_cnt_q + CNT_SIZE'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    len_d       = frame_len_i;
                    nb_d        = nb_frames_i;
                    frame_cnt_d = {CNT_SIZE{1'b0}};
                    state_d     = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (fwd && last && (stop_i || last_frame)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (stop_i) begin
                    // a sample arriving with stop opens a frame that must be finished
                    if (!fwd && first) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (fwd && last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        en_d   = fwd;
        sof_d  = fwd && first;
        eof_d  = fwd && last;
        if (data_en_i) begin
            di_d = data_i_i;
            dq_d = data_q_i;
        end else begin
            di_d = di_q;
            dq_d = dq_q;
        end
    end

    // state, config and output registers
    always_ff @(posedge data_clk_i or posedge data_rst_i) begin
        if (data_rst_i) begin
            state_q     <= ST_IDLE;
            len_q       <= {LEN_SIZE{1'b0}};
            nb_q        <= {CNT_SIZE{1'b0}};
            frame_cnt_q <= {CNT_SIZE{1'b0}};
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            di_q        <= {DATA_SIZE{1'b0}};
            dq_q        <= {DATA_SIZE{1'b0}};
            en_q        <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            nb_q        <= nb_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            di_q        <= di_d;
            dq_q        <= dq_d;
            en_q        <= en_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
        end
    end

    assign data_i_o    = di_q;
    assign data_q_o    = dq_q;
    assign data_en_o   = en_q;
    assign data_sof_o  = sof_q;
    assign data_eof_o  = eof_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
